// File: rtl/freqdiv_multi.sv
// Multi-channel programmable clock divider: per-channel square/pulse output,
// divisor and mode shadowed to period boundaries, shared sync_start re-phasing.
module freqdiv_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned N_WIDTH  = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS*N_WIDTH-1:0]  div_n,
  input  logic [CHANNELS-1:0]          mode,
  input  logic                         sync_start,
  output logic [CHANNELS-1:0]          clk_out,
  output logic [CHANNELS-1:0]          period_tick,
  output logic [CHANNELS-1:0]          active
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  generate
    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
      state_t             r_state;
      state_t             w_state_nxt;
      logic [N_WIDTH-1:0] r_cnt;
      logic [N_WIDTH-1:0] w_cnt_nxt;
      logic [N_WIDTH-1:0] r_act_n;
      logic [N_WIDTH-1:0] w_act_n_nxt;
      logic               r_act_mode;
      logic               w_act_mode_nxt;
      logic               r_clk;
      logic               r_tick;
      logic               r_active;
      logic               w_clk_nxt;
      logic               w_tick_nxt;
      logic [N_WIDTH-1:0] w_div;
      logic               w_boundary;
      logic               w_reload;
      logic [N_WIDTH:0]   w_half;

      assign w_div      = div_n[gc*N_WIDTH +: N_WIDTH];
      assign w_boundary = (r_cnt == r_act_n - N_WIDTH'(1));
      assign w_reload   = sync_start || w_boundary;

      // Next-state: en low, then zero-divisor reload, then restart/boundary, then count.
      always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_act_n_nxt    = r_act_n;
        w_act_mode_nxt = r_act_mode;
        if (!en[gc]) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_act_n_nxt    = '0;
          w_act_mode_nxt = 1'b0;
        end else begin
          unique case (r_state)
            S_IDLE: begin
              if (w_div != '0) begin
                w_state_nxt    = S_RUN;
                w_cnt_nxt      = '0;
                w_act_n_nxt    = w_div;
                w_act_mode_nxt = mode[gc];
              end
            end
            S_RUN: begin
              if (w_reload && (w_div == '0)) begin
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
                w_act_n_nxt    = '0;
                w_act_mode_nxt = 1'b0;
              end else if (w_reload) begin
                w_cnt_nxt      = '0;
                w_act_n_nxt    = w_div;
                w_act_mode_nxt = mode[gc];
              end else begin
                w_cnt_nxt = r_cnt + N_WIDTH'(1);
              end
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end

      // Outputs are computed from next state so they register alongside cnt.
      always_comb begin
        w_half     = ({1'b0, w_act_n_nxt} + (N_WIDTH+1)'(1)) >> 1;
        w_clk_nxt  = 1'b0;
        w_tick_nxt = 1'b0;
        if (w_state_nxt == S_RUN) begin
          if (w_act_n_nxt == N_WIDTH'(1)) begin
            w_clk_nxt = 1'b1;
          end else if (w_act_mode_nxt) begin
            w_clk_nxt = (w_cnt_nxt == '0);
          end else begin
            w_clk_nxt = ({1'b0, w_cnt_nxt} < w_half);
          end
          w_tick_nxt = (w_cnt_nxt == w_act_n_nxt - N_WIDTH'(1));
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_act_n    <= '0;
          r_act_mode <= 1'b0;
          r_clk      <= 1'b0;
          r_tick     <= 1'b0;
          r_active   <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_cnt      <= w_cnt_nxt;
          r_act_n    <= w_act_n_nxt;
          r_act_mode <= w_act_mode_nxt;
          r_clk      <= w_clk_nxt;
          r_tick     <= w_tick_nxt;
          r_active   <= (w_state_nxt == S_RUN);
        end
      end

      assign clk_out[gc]     = r_clk;
      assign period_tick[gc] = r_tick;
      assign active[gc]      = r_active;
    end
  endgenerate

endmodule

// File: doc/freqdiv_multi.md
Name: freqdiv_multi

Overview:
Parametrised multi-channel programmable clock divider. It is the successor to the single-channel 4-bit divider driven from mprj_io. Each channel divides wb_clk_i by its own N_WIDTH-bit divisor and offers two output modes: square (near-50% duty) or single-cycle pulse. Divisor and mode changes are shadowed and applied only at period boundaries, so outputs never glitch. A common sync_start strobe phase-aligns all channels. The block sits inside user_project_wrapper, with inputs and outputs routed to mprj_io or logic analyzer pins.

Parameters:
CHANNELS, 4, number of independent divider channels (1..8)
N_WIDTH, 8, divisor width per channel (2..16)

Ports:
wb_clk_i  input  1  system clock; all logic on rising edge
wb_rst_i  input  1  synchronous reset, active-high
en  input  CHANNELS  per-channel enable, level-sensitive
div_n  input  CHANNELS*N_WIDTH  divisor for channel c in bits [c*N_WIDTH +: N_WIDTH]
mode  input  CHANNELS  per-channel mode: 0 = square, 1 = pulse
sync_start  input  1  one-cycle strobe; restarts all running channels in phase
clk_out  output  CHANNELS  divided outputs, registered
period_tick  output  CHANNELS  one-cycle pulse, registered, on the last cycle of each period
active  output  CHANNELS  channel running (not idle), registered

Behaviour:
- Reset (wb_rst_i=1 at an edge): all channels go to IDLE. clk_out=0, period_tick=0, active=0, cnt=0, act_n=0, act_mode=0. Reset overrides all other inputs.
- Per-channel state: cnt[N_WIDTH-1:0], act_n, act_mode, plus IDLE/RUN.
- IDLE -> RUN: at an edge where en[c]=1 and div_n[c]!=0.
  - Next cycle: cnt=0, act_n=div_n[c], act_mode=mode[c], active=1.
  - clk_out=1 on that first cycle, so latency from en sampled to first high is 1 cycle.
- IDLE with en[c]=1 and div_n[c]=0: remains IDLE, outputs 0.
- RUN: cnt increments each cycle. When cnt==act_n-1, the next cnt=0 and act_n/act_mode reload from div_n[c]/mode[c] (the boundary).
- clk_out rule, for the registered cycle with count cnt:
  - Square: high while cnt < H, where H=(act_n+1)>>1. Odd n gives one extra high cycle.
  - Pulse: high only when cnt==0.
  - act_n==1: clk_out held constant 1 in both modes.
- period_tick=1 exactly in cycles where cnt==act_n-1. It is constant 1 when act_n==1.
- Divisor or mode changes mid-period have no effect until the boundary. The current period always completes with its old values.
- Reload of div_n[c]==0 at a boundary: channel goes to IDLE next cycle (all outputs 0). It restarts as IDLE -> RUN once div_n becomes nonzero.
- en[c] deasserted at an edge: channel goes to IDLE next cycle (cnt=0, outputs 0) immediately, without finishing the period.
- sync_start=1 at an edge: every channel that is RUN, or qualifies for IDLE -> RUN, takes cnt=0 and reloads act_n/act_mode from the inputs (restart, clk_out=1 next cycle). Channels with en=0 are unaffected.
- Priority per channel: wb_rst_i > en low > div_n==0 reload > sync_start > boundary reload > increment.
- Arithmetic: cnt and the compare are N_WIDTH unsigned. The max divisor 2^N_WIDTH-1 must not overflow cnt. H is computed in N_WIDTH+1 bits.
- Channels are fully independent except through the shared sync_start.
- Outputs are driven only from flops. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then en[0]=1, div_n=3, mode=0 -> clk_out[0] starts 1 cycle later, pattern 1,1,0 repeating. period_tick high on every 3rd cycle (cnt=2).
- div_n=4 square, switch to 11 at cnt=1 -> remainder of current period stays 1,1,0,0. Next period is 6 high, 5 low, with no short or runt pulse.
- mode=1, div_n=6 -> pattern 1,0,0,0,0,0. Change mode to 0 mid-period -> the next period (not the current one) becomes 1,1,1,0,0,0.
- div_n=1 -> clk_out and period_tick constant 1. div_n=0 at the boundary -> active falls next cycle and clk_out=0. div_n=5 later -> restarts with 1,1,1,0,0.
- Channels 0..3 with div_n=4,6,8,3, started at staggered times, then one sync_start pulse -> the cycle after, all clk_out=1 with cnt=0. Phase stays aligned thereafter (common edge every 24 cycles). A channel with en=0 stays 0.
- Mid-period wb_rst_i pulse, and separately en drop at cnt=2 of n=7 -> next cycle all outputs 0 and active=0. Re-enable gives a clean restart from cnt=0.
